// File: rtl/repeat_capture_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// repeat_capture_pkg : shared limits and count-step helper for the capture queue
// rev 1.0
// ----------------------------------------------------------------------------
package repeat_capture_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int MAX_CW    = 16;

  typedef struct packed {
    logic              done;
    logic [MAX_CW-1:0] count;
  } count_step_t;

  // Count is carried at MAX_CW bits so one helper serves every CW <= MAX_CW.
  function automatic count_step_t next_count(input logic [MAX_CW-1:0] count, input logic ev);
    count_step_t step;
    step.count = count;
    if (ev && (count != '0)) step.count = count - MAX_CW'(1);
    step.done = (step.count == '0);
    return step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/repeat_capture_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// repeat_capture_slot : one sampled entry with its remaining event count
// rev 1.0
// ----------------------------------------------------------------------------
module repeat_capture_slot #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    load_count,
  output logic             valid,
  output logic             done,
  output logic [WIDTH-1:0] data
);
  import repeat_capture_pkg::*;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t      r_entry;
  count_step_t w_step;

  always_comb w_step = next_count(MAX_CW'(r_entry.count), ev);

  // Load wins over clear: the top never loads the slot it is popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (load) begin
      r_entry.valid <= 1'b1;
      r_entry.done  <= (load_count == '0);
      r_entry.count <= load_count;
      r_entry.data  <= load_data;
    end else if (clear) begin
      r_entry <= '0;
    end else if (r_entry.valid && !r_entry.done) begin
      r_entry.count <= w_step.count[CW-1:0];
      r_entry.done  <= w_step.done;
    end
  end

  assign valid = r_entry.valid;
  assign done  = r_entry.done;
  assign data  = r_entry.data;

endmodule
`default_nettype wire

// File: rtl/repeat_capture_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// repeat_capture_queue : in-order queue of sampled words released after n events
// rev 1.0
// ----------------------------------------------------------------------------
module repeat_capture_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ev,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_data,
  input  logic [CW-1:0]          req_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] C_DEPTH = OW'(DEPTH);

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;
  logic             w_push;
  logic             w_pop;
  logic             w_valid [DEPTH];
  logic             w_done  [DEPTH];
  logic [WIDTH-1:0] w_data  [DEPTH];

  assign req_ready = !flush && (r_occ < C_DEPTH);
  assign out_valid = w_valid[r_head] && w_done[r_head];
  assign out_data  = out_valid ? w_data[r_head] : '0;
  assign occupancy = r_occ;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    repeat_capture_slot #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .ev         (ev),
      .load       (w_push && (r_tail == PW'(i))),
      .clear      (flush || (w_pop && (r_head == PW'(i)))),
      .load_data  (req_data),
      .load_count (req_count),
      .valid      (w_valid[i]),
      .done       (w_done[i]),
      .data       (w_data[i])
    );
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OW'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_repeat_capture_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_repeat_capture_queue : scenario tasks with a data scoreboard
// rev 1.0
// ----------------------------------------------------------------------------
module tb_repeat_capture_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [7:0]  req_count = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  repeat_capture_queue #(.WIDTH(32), .DEPTH(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev        (ev),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_count (req_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_data = 32'hDEAD_BEEF; req_count = 8'd5; ev = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL midwait_occ: got %0d expected 1", occupancy); end
    #3 rst = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL async_reset_occ: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_after_reset: got %b expected 0 at cycle %0d", out_valid, i); end
    end
    ev = 1'b0;
  endtask

  task automatic test_repeat3();
    ev = 1'b1; out_ready = 1'b0;
    req_valid = 1'b1; req_data = 32'd42; req_count = 8'd3;
    exp_q.push_back(32'd42);
    step();
    req_valid = 1'b0; req_data = 32'd7;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rep3_early: got %b expected 0 at cycle %0d", out_valid, i + 1); end
      step();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rep3_latency: got %b expected 1", out_valid); end
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL rep3_data: got %0d expected %0d", out_data, exp_q[0]); end
    step();
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL rep3_hold: got %0d expected %0d", out_data, exp_q[0]); end
    out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rep3_pop_occ: got %0d expected 0", occupancy); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rep3_idle_data: got %0h expected 0", out_data); end
  endtask

  task automatic test_zero_count();
    ev = 1'b0;
    req_valid = 1'b1; req_data = 32'hA5; req_count = 8'd0;
    exp_q.push_back(32'hA5);
    step();
    req_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL zero_data: got %0h expected %0h", out_data, exp_q[0]); end
    out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL zero_pop_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_in_order();
    ev = 1'b0; out_ready = 1'b0;
    req_valid = 1'b1; req_data = 32'hAAAA; req_count = 8'd2;
    exp_q.push_back(32'hAAAA);
    step();
    req_data = 32'hBBBB; req_count = 8'd1;
    exp_q.push_back(32'hBBBB);
    step();
    req_valid = 1'b0; ev = 1'b1;
    step();
    ev = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_head_block: got %b expected 0", out_valid); end
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL order_occ: got %0d expected 2", occupancy); end
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_sparse: got %b expected 0", out_valid); end
    ev = 1'b1;
    step();
    ev = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL order_first: got %b/%0h expected 1/%0h", out_valid, out_data, exp_q[0]); end
    out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL order_second: got %b/%0h expected 1/%0h", out_valid, out_data, exp_q[0]); end
    step();
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL order_drain_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_full();
    ev = 1'b0; out_ready = 1'b0; req_count = 8'd0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = 32'h100 + 32'(i);
      exp_q.push_back(req_data);
      step();
    end
    req_data = 32'h200;
    #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", req_ready); end
    step();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_held: got %0d expected 4", occupancy); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL full_pop_data: got %0h expected %0h", out_data, exp_q[0]); end
    step();
    void'(exp_q.pop_front());
    checks++; if (occupancy !== 3'd3 || req_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %0d/%b expected 3/1", occupancy, req_ready); end
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL pushpop_data: got %0h expected %0h", out_data, exp_q[0]); end
    exp_q.push_back(32'h200);
    step();
    void'(exp_q.pop_front());
    req_valid = 1'b0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL pushpop_occ: got %0d expected 3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL full_drain: got %b/%0h expected 1/%0h", out_valid, out_data, exp_q[0]); end
      step();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_drain_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_flush();
    ev = 1'b1; out_ready = 1'b0;
    req_valid = 1'b1; req_data = 32'h55; req_count = 8'd1;
    exp_q.push_back(32'h55);
    step();
    req_valid = 1'b0; ev = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL accept_edge_ev: got %b expected 0", out_valid); end
    ev = 1'b1;
    step();
    ev = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL accept_edge_done: got %b/%0h expected 1/%0h", out_valid, out_data, exp_q[0]); end
    out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    req_valid = 1'b1; req_data = 32'h66; req_count = 8'd5;
    step();
    req_valid = 1'b0; ev = 1'b1;
    step();
    flush = 1'b1; req_valid = 1'b1; req_data = 32'h77; req_count = 8'd0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %0d/%b expected 0/0", occupancy, out_valid); end
    for (int i = 0; i < 6; i++) step();
    ev = 1'b0;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_push: got %0d/%b expected 0/0", occupancy, out_valid); end
  endtask

  task automatic test_back_to_back();
    bit drained;
    for (int cyc = 0; cyc < 200; cyc++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_data  = $urandom;
      req_count = 8'($urandom_range(0, 4));
      ev        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (!out_valid) begin
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL b2b_idle_data: got %0h expected 0", out_data); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got %0h expected none", out_data); end
        else begin
          if (out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data: got %0h expected %0h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) exp_q.push_back(req_data);
      step();
      checks++; if (occupancy !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_occ: got %0d expected %0d", occupancy, exp_q.size()); end
    end
    req_valid = 1'b0; ev = 1'b1; out_ready = 1'b1;
    drained = 1'b0;
    for (int cyc = 0; cyc < 100 && !drained; cyc++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL drain_unexpected: got %0h expected none", out_data); end
        else begin
          if (out_data !== exp_q[0]) begin errors++; $display("FAIL drain_data: got %0h expected %0h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      step();
      if (exp_q.size() == 0 && occupancy == 3'd0) drained = 1'b1;
    end
    checks++; if (!drained) begin errors++; $display("FAIL drain_budget: got %0d left expected 0", exp_q.size()); end
    ev = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_repeat3();
    test_zero_count();
    test_in_order();
    test_full();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
